// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory slave for the ireq/dreq fetch and data ports.
// Define MEM_RESP_RANDOM_LAT_EN to add 0..3 LFSR-driven extra latency cycles per request.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 5;

    if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
        $error("mem_responder: LATENCY must be in 1..15");
    end
    if ((1 << AW) != DEPTH_WORDS) begin : gBadDepth
        $error("mem_responder: DEPTH_WORDS must be a power of two");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
    typedef enum logic {GRANT_I, GRANT_D} grantT;

    stateT         state, stateNext;
    grantT         lastGrant, lastGrantNext;
    logic [CW-1:0] cnt, cntNext;
    logic [CW-1:0] loadVal;
    logic [AW-1:0] idx, idxNext;
    logic          hiHalf, hiHalfNext;
    logic [7:0]    strobe, strobeNext;
    logic [63:0]   wdata, wdataNext;
    logic [63:0]   rdWord;
    logic [63:0]   mem [DEPTH_WORDS];

    logic unusedAddrBits;
    assign unusedAddrBits = ^{ireq_addr[63:3+AW], ireq_addr[1:0],
                              dreq_addr[63:3+AW], dreq_addr[2:0]};

`ifdef MEM_RESP_RANDOM_LAT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        loadVal = CW'(LATENCY - 1) + {3'b000, lfsr[1:0]};
    end
`else
    always_comb begin
        loadVal = CW'(LATENCY - 1);
    end
`endif

    // lastGrant doubles as the channel of the transaction in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            lastGrant <= GRANT_I;
            cnt       <= '0;
            idx       <= '0;
            hiHalf    <= 1'b0;
            strobe    <= '0;
            wdata     <= '0;
        end else begin
            state     <= stateNext;
            lastGrant <= lastGrantNext;
            cnt       <= cntNext;
            idx       <= idxNext;
            hiHalf    <= hiHalfNext;
            strobe    <= strobeNext;
            wdata     <= wdataNext;
        end
    end

    always_comb begin
        stateNext     = state;
        lastGrantNext = lastGrant;
        cntNext       = cnt;
        idxNext       = idx;
        hiHalfNext    = hiHalf;
        strobeNext    = strobe;
        wdataNext     = wdata;
        unique case (state)
            IDLE: begin
                if (ireq_valid || dreq_valid) begin
                    if (dreq_valid && (!ireq_valid || lastGrant == GRANT_I)) begin
                        lastGrantNext = GRANT_D;
                        idxNext       = dreq_addr[3 +: AW];
                        hiHalfNext    = 1'b0;
                        strobeNext    = dreq_strobe;
                        wdataNext     = dreq_data;
                    end else begin
                        lastGrantNext = GRANT_I;
                        idxNext       = ireq_addr[3 +: AW];
                        hiHalfNext    = ireq_addr[2];
                        strobeNext    = '0;
                        wdataNext     = '0;
                    end
                    cntNext   = loadVal;
                    stateNext = (loadVal != '0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cntNext = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                cntNext   = '0;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        rdWord        = mem[idx];
        iresp_data_ok = (state == RESP) && (lastGrant == GRANT_I);
        dresp_data_ok = (state == RESP) && (lastGrant == GRANT_D);
        iresp_data    = '0;
        dresp_data    = '0;
        if (iresp_data_ok) begin
            iresp_data = hiHalf ? rdWord[63:32] : rdWord[31:0];
        end
        if (dresp_data_ok) begin
            dresp_data = rdWord;
        end
    end

    // The response reads pre-write contents combinationally; the strobed bytes land at the RESP edge.
    always_ff @(posedge clk) begin
        if (resetn && dresp_data_ok) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (strobe[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
